// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings
// and the default sequential PC increment.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam int DEFAULT_PC_STEP = 4;

endpackage

// File: rtl/pc_fetch_unit_pc_register.sv
// Program counter storage: XLEN-bit register with synchronous reset to
// RESET_PC and a load enable.
module pc_register #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] pc
);

  // Hold the PC unless a load is requested; reset restores the boot address.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= load_val;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues one outstanding request to
// instruction memory, holds the returned word until decode takes it, and
// handles stall and redirect/flush. The next-PC mux lives outside; this
// block supplies pc_plus4 to it and loads whatever comes back.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] next_pc_in,
  input  logic            redirect,
  output logic [XLEN-1:0] pc_plus4,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  fetch_state_e    state, state_nxt;
  logic            drop, drop_nxt;
  logic [XLEN-1:0] ir, ir_nxt;
  logic [XLEN-1:0] pc;
  logic            pc_load;
  logic [XLEN-1:0] pc_aligned;

  // Every PC load is word-aligned by clearing the two low bits.
  assign pc_aligned = next_pc_in & ~XLEN'(3);
  assign pc_plus4   = pc + XLEN'(PC_STEP);

  pc_register #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk      (clk),
    .rst      (rst),
    .load_en  (pc_load),
    .load_val (pc_aligned),
    .pc       (pc)
  );

  // State, drop flag and instruction register; reset clears any pending drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      drop  <= 1'b0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
      ir    <= ir_nxt;
    end
  end

  // Next-state and PC-load decisions; a redirect always loads the PC and
  // abandons whatever the current state was waiting on.
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    ir_nxt    = ir;
    pc_load   = redirect;
    case (state)
      FETCH: begin
        if (imem_req_ready) begin
          state_nxt = WAIT;
          if (redirect) begin
            drop_nxt = 1'b1;
          end
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (drop || redirect) begin
            drop_nxt  = 1'b0;
            state_nxt = FETCH;
          end else begin
            ir_nxt    = imem_rsp_data;
            state_nxt = HOLD;
          end
        end else if (redirect) begin
          drop_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_nxt = FETCH;
        end else if (if_ready) begin
          pc_load   = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  assign imem_req_valid = (state == FETCH);
  assign imem_addr      = pc;
  assign if_valid       = (state == HOLD);
  assign if_pc          = pc;
  assign if_instr       = ir;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit: sequential fetch, stall, the three
// redirect timings, alignment, reset mid-WAIT, and PC wrap on a second
// instance booting at the top of the address space.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] next_pc_in;
  logic [31:0] pc_plus4;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  logic        w_req_ready;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_if_ready;
  logic [31:0] w_next_pc_in;
  logic [31:0] w_pc_plus4;
  logic        w_req_valid;
  logic [31:0] w_addr;
  logic        w_if_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_instr;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // External next-PC mux: sequential path unless a taken target is selected.
  assign next_pc_in   = redirect ? target : pc_plus4;
  assign w_next_pc_in = w_pc_plus4;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .next_pc_in     (next_pc_in),
    .redirect       (redirect),
    .pc_plus4       (pc_plus4),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .next_pc_in     (w_next_pc_in),
    .redirect       (1'b0),
    .pc_plus4       (w_pc_plus4),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (w_req_ready),
    .imem_addr      (w_addr),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .if_valid       (w_if_valid),
    .if_ready       (w_if_ready),
    .if_pc          (w_if_pc),
    .if_instr       (w_if_instr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic rspv, input logic [31:0] data,
                               input logic redir, input logic [31:0] tgt, input logic ifr);
    imem_req_ready = rdy;
    imem_rsp_valid = rspv;
    imem_rsp_data  = data;
    redirect       = redir;
    target         = tgt;
    if_ready       = ifr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full fetch with zero-wait memory and decode ready.
  task automatic fetchOne(input logic [31:0] exp_addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("seq_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("seq_addr", imem_addr, exp_addr);
    step();
    applyStimulus(1'b1, 1'b1, data, 1'b0, 32'h0, 1'b1);
    checkOutput("seq_wait_ifv", {31'b0, if_valid}, 32'd0);
    step();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("seq_ifv", {31'b0, if_valid}, 32'd1);
    checkOutput("seq_instr", if_instr, data);
    checkOutput("seq_pc", if_pc, exp_addr);
    step();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_data  = 32'h0;
    w_if_ready  = 1'b0;
    step();
    step();
    rst = 1'b0;

    checkOutput("rst_ifv", {31'b0, if_valid}, 32'd0);
    checkOutput("rst_instr", if_instr, 32'h0);
    checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_pc_plus4", pc_plus4, 32'h4);
    checkOutput("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    checkOutput("wrap_pc_plus4", w_pc_plus4, 32'h0);

    for (int i = 0; i < 3; i++) begin
      fetchOne(32'(i * 4), 32'h0000_0013);
    end

    // Stall five cycles in HOLD at pc 12.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 32'h0000_000A, 1'b0, 32'h0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_ifv", {31'b0, if_valid}, 32'd1);
      checkOutput("stall_pc", if_pc, 32'd12);
      checkOutput("stall_instr", if_instr, 32'h0000_000A);
      checkOutput("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
      step();
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    checkOutput("release_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("release_addr", imem_addr, 32'd16);

    // Redirect in WAIT with no reply: late reply dropped, refetch at 0x100.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 32'h0000_0BAD, 1'b0, 32'h0, 1'b0);
    checkOutput("wredir_req_valid", {31'b0, imem_req_valid}, 32'd0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("wredir_ifv", {31'b0, if_valid}, 32'd0);
    checkOutput("wredir_req_valid2", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("wredir_addr", imem_addr, 32'h100);

    // Redirect coincident with the reply.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 32'h0000_DEAD, 1'b1, 32'h200, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("rspredir_ifv", {31'b0, if_valid}, 32'd0);
    checkOutput("rspredir_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("rspredir_addr", imem_addr, 32'h200);

    // Redirect coincident with request acceptance.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 32'h0000_BEEF, 1'b0, 32'h0, 1'b0);
    checkOutput("accredir_req_valid", {31'b0, imem_req_valid}, 32'd0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("accredir_ifv", {31'b0, if_valid}, 32'd0);
    checkOutput("accredir_addr", imem_addr, 32'h300);

    // Redirect from HOLD to a misaligned target: flush and fetch at 0x100.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 32'h0000_0077, 1'b0, 32'h0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h103, 1'b0);
    checkOutput("hold_ifv", {31'b0, if_valid}, 32'd1);
    checkOutput("hold_instr", if_instr, 32'h0000_0077);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("flush_ifv", {31'b0, if_valid}, 32'd0);
    checkOutput("align_addr", imem_addr, 32'h100);

    // Redirect in FETCH without acceptance, then a stray reply in FETCH.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 32'h0000_1111, 1'b0, 32'h0, 1'b0);
    checkOutput("fredir_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("fredir_addr", imem_addr, 32'h40);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("stray_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("stray_ifv", {31'b0, if_valid}, 32'd0);

    // Reset mid-WAIT, then a late reply must not be taken.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("midwait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rstwait_addr", imem_addr, 32'h0);
    checkOutput("rstwait_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("rstwait_ifv", {31'b0, if_valid}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0000_2222, 1'b0, 32'h0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("late_rsp_ifv", {31'b0, if_valid}, 32'd0);
    checkOutput("late_rsp_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("late_rsp_instr", if_instr, 32'h0);

    // Wrap instance: fetch at 0xFFFFFFFC, next fetch at 0.
    w_req_ready = 1'b1;
    checkOutput("wrap_addr", w_addr, 32'hFFFF_FFFC);
    step();
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b1;
    w_rsp_data  = 32'h0000_0013;
    step();
    w_rsp_valid = 1'b0;
    w_if_ready  = 1'b1;
    checkOutput("wrap_ifv", {31'b0, w_if_valid}, 32'd1);
    checkOutput("wrap_if_pc", w_if_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_instr", w_if_instr, 32'h0000_0013);
    step();
    w_if_ready = 1'b0;
    checkOutput("wrap_next_req", {31'b0, w_req_valid}, 32'd1);
    checkOutput("wrap_next_addr", w_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
